divmod_n: RTL and testbench
===========================

Name: divmod_n

Overview:
- Parametrised multi-cycle integer divider producing quotient and remainder. Successor to the fixed 16-bit unsigned divmod.
- Adds generic width, a per-operation signed/unsigned mode, explicit busy status, and divide-by-zero/overflow reporting.
- Uses a restoring radix-2 datapath, one quotient bit per clock.
- Used by the prime-generation datapath and any arithmetic unit needing div/mod without a combinational divider.

Parameters:
- WIDTH, 16, operand/result width in bits (>= 2).
- SIGNED_EN, 1, 1 = signed mode available via sgn port; 0 = sgn ignored, unsigned logic only.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- go  in  1  start request, sampled on rising clk.
- sgn  in  1  1 = signed two's-complement operation; sampled with go.
- a  in  WIDTH  dividend, sampled with go.
- b  in  WIDTH  divisor, sampled with go.
- busy  out  1  operation in progress.
- ready  out  1  results valid.
- error  out  1  divide-by-zero, or signed overflow; valid while ready=1.
- div  out  WIDTH  quotient.
- mod  out  WIDTH  remainder.

Behaviour:
- Reset: busy=0, ready=0, error=0, div=0, mod=0, FSM=IDLE. Reset mid-operation aborts immediately; no result is produced.
- FSM states: IDLE, CALC, FIX.
- IDLE, go=1 at edge T:
  - Latch operands and mode; ready<=0, busy<=1.
  - If b==0: go to FIX, flagged error.
  - Else: load |a|, |b| (magnitudes in signed mode), counter=WIDTH-1, go to CALC.
- CALC: one restoring step per cycle.
  - rem = {rem[WIDTH-2:0], quo[WIDTH-1]}; quo <<= 1; if rem >= |b| then rem -= |b| and quo[0]=1.
  - Counter decrements; at 0 go to FIX.
  - Remainder register is WIDTH+1 bits internally so the subtract never overflows.
- FIX: apply signs, drive outputs, busy<=0, ready<=1, go to IDLE.
  - Signed: quotient negated if sign(a)!=sign(b); remainder takes sign of a. Truncation toward zero, i.e. C semantics.
- Latency: go at edge T -> ready=1 after edge T+WIDTH+1. Divide-by-zero: ready after edge T+2.
- Divide by zero: error=1, div = all ones, mod = a (unsigned and signed alike).
- Signed overflow (a = most-negative, b = -1): error=1, div = a, mod = 0.
- All other cases: error=0.
- ready, error, div, mod hold until the next accepted go. They clear on the edge that accepts it: ready and error go to 0; div and mod keep stale values until FIX.
- go while busy=1 is ignored; no queuing.
- go held high continuously restarts on the cycle after ready rises.
- SIGNED_EN=0: sgn treated as 0; sign logic may be optimised away.

Decomposition:
- Package divmod_pkg:
  - FSM state enum (IDLE, CALC, FIX).
  - Helper function abs_val(value, sgn).
  - Localparam CNT_W = $clog2(WIDTH).
- One sub-module, divmod_step: combinational single restoring iteration.
  - Inputs: rem, quo msb, divisor.
  - Outputs: next rem, next quotient bit.
  - Lets an unrolled two-bits-per-cycle variant be added later.

Test Plan:
- Exhaustive unsigned sweep, WIDTH=8, sgn=0, a,b in 0..255:
  - b!=0 -> div=a/b, mod=a%b, error=0, ready exactly 9 cycles after go.
  - b=0 -> div=8'hFF, mod=a, error=1, ready 2 cycles after go.
- WIDTH=16, sgn=1, four sign combinations:
  - (-7,2) -> div=-3, mod=-1.
  - (7,-2) -> div=-3, mod=1.
  - (-7,-2) -> div=3, mod=-1.
  - (7,2) -> div=3, mod=1.
- WIDTH=16, sgn=1, a=16'h8000, b=16'hFFFF -> div=16'h8000, mod=0, error=1.
- Busy rejection: go at T with (100,7), second go at T+3 with (5,5) -> only div=14, mod=2 reported. busy stays high T+1..T+17, ready once.
- Reset mid-op: assert rst for 1 cycle 5 cycles into a WIDTH=16 operation -> all outputs 0, next go (1000,10) -> div=100, mod=0.
- Back-to-back: go held high over three operand pairs -> each result appears with ready=1 for exactly one cycle before the next acceptance, all values correct.

Source files
------------

// File: rtl/divmod_pkg.sv
// Shared types and helpers for the radix-2 restoring divider family.
// Provides the FSM state type, the operand magnitude helper and the default counter width.
package divmod_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  // Widest operand abs_val() can take; callers sign-extend into this container.
  localparam int MAX_W     = 64;
  localparam int DEF_WIDTH = 16;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  // Magnitude of a sign-extended operand; only negated when signed mode is active.
  function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] value,
                                               input logic              sgn);
    if (sgn && value[MAX_W-1]) return -value;
    return value;
  endfunction

endpackage

// File: rtl/divmod_step.sv
// One restoring division iteration: shift in the next dividend bit, then trial-subtract.
// Kept separate so several copies can later be chained for more bits per clock.
module divmod_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   rem,
  input  logic             quo_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] ext_div;

  always_comb begin
    shifted  = {rem, quo_msb};
    ext_div  = {2'b00, divisor};
    q_bit    = (shifted >= ext_div);
    rem_next = q_bit ? (WIDTH+1)'(shifted - ext_div) : shifted[WIDTH:0];
  end

endmodule

// File: rtl/divmod_n.sv
// Multi-cycle integer divider, one quotient bit per clock, with optional signed mode.
// Magnitudes are divided unsigned; signs are applied in the FIX state (C truncation semantics).
module divmod_n
  import divmod_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             ready,
  output logic             error,
  output logic [WIDTH-1:0] div,
  output logic [WIDTH-1:0] mod
);

  localparam int CNT_BITS = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                  input logic             neg);
    logic signed [WIDTH-1:0] smag;
    smag = signed'(mag);
    return neg ? -smag : smag;
  endfunction

  state_t              state;
  state_t              state_next;
  logic [CNT_BITS-1:0] cnt;
  logic [WIDTH:0]      rem;
  logic [WIDTH:0]      rem_next;
  logic [WIDTH-1:0]    quo;
  logic [WIDTH-1:0]    dvs;
  logic [WIDTH-1:0]    a_hold;
  logic [WIDTH-1:0]    a_mag;
  logic [WIDTH-1:0]    b_mag;
  logic                q_bit;
  logic                sgn_eff;
  logic                accept;
  logic                div_zero;
  logic                ovf;
  logic                neg_q;
  logic                neg_r;
  logic                zero_flag;
  logic                err_flag;

  assign sgn_eff  = sgn & SIGNED_EN;
  assign accept   = (state == IDLE) && go;
  assign div_zero = (b == '0);
  assign ovf      = sgn_eff && (a == MOST_NEG) && (&b);
  assign a_mag    = WIDTH'(abs_val(MAX_W'(signed'(a)), sgn_eff));
  assign b_mag    = WIDTH'(abs_val(MAX_W'(signed'(b)), sgn_eff));

  divmod_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo_msb  (quo[WIDTH-1]),
    .divisor  (dvs),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (go) state_next = CALC;
      CALC:    if (cnt == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control: FSM, counter and the held result registers.
  // Divide-by-zero runs a single dummy step so its result lands two edges after go.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      ready <= 1'b0;
      error <= 1'b0;
      div   <= '0;
      mod   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        busy  <= 1'b1;
        ready <= 1'b0;
        error <= 1'b0;
        cnt   <= div_zero ? '0 : CNT_BITS'(WIDTH-1);
      end else if (state == CALC) begin
        cnt <= cnt - CNT_BITS'(1);
      end else if (state == FIX) begin
        busy  <= 1'b0;
        ready <= 1'b1;
        error <= err_flag;
        if (zero_flag) begin
          div <= '1;
          mod <= a_hold;
        end else begin
          div <= apply_sign(quo, neg_q);
          mod <= apply_sign(rem[WIDTH-1:0], neg_r);
        end
      end
    end
  end

  // Datapath: operand capture and restoring iterations.
  // Signed overflow needs no special result path: |MIN|/1 yields MIN, remainder 0.
  always_ff @(posedge clk) begin
    if (accept) begin
      dvs       <= b_mag;
      quo       <= a_mag;
      rem       <= '0;
      a_hold    <= a;
      neg_q     <= sgn_eff & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r     <= sgn_eff & a[WIDTH-1];
      zero_flag <= div_zero;
      err_flag  <= div_zero | ovf;
    end else if (state == CALC) begin
      rem <= rem_next;
      quo <= {quo[WIDTH-2:0], q_bit};
    end
  end

endmodule

// File: tb/tb_divmod_n.sv
// Bench for divmod_n (WIDTH=16): cycle-level behavioural model with per-cycle comparison,
// literal checks on the model and on directed DUT operations, then randomized traffic.
module tb_divmod_n;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         go  = 1'b0;
  logic         sgn = 1'b0;
  logic [W-1:0] a   = '0;
  logic [W-1:0] b   = '0;
  logic         busy, ready, error;
  logic [W-1:0] div, mod;

  int tests  = 0;
  int fails  = 0;
  int nprint = 0;
  logic chk_en = 1'b0;

  divmod_n #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk   (clk),
    .rst   (rst),
    .go    (go),
    .sgn   (sgn),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .ready (ready),
    .error (error),
    .div   (div),
    .mod   (mod)
  );

  always #5 clk = ~clk;

  // Reference arithmetic straight from the rules (C truncating division for signed).
  task automatic ref_div(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rs,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic e);
    int sa, sb;
    if (rb == 0) begin
      q = '1; r = ra; e = 1'b1;
    end else if (rs) begin
      sa = int'($signed(ra));
      sb = int'($signed(rb));
      if (sa == -32768 && sb == -1) begin
        q = ra; r = '0; e = 1'b1;
      end else begin
        q = W'(sa / sb); r = W'(sa % sb); e = 1'b0;
      end
    end else begin
      q = ra / rb; r = ra % rb; e = 1'b0;
    end
  endtask

  // Cycle-level model: an accepted op finishes a fixed number of edges later.
  logic         m_busy = 1'b0, m_ready = 1'b0, m_error = 1'b0;
  logic [W-1:0] m_div = '0, m_mod = '0;
  logic [W-1:0] p_div = '0, p_mod = '0;
  logic         p_err = 1'b0;
  int           m_left = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_ready = 1'b0; m_error = 1'b0;
      m_div = '0; m_mod = '0; m_left = 0;
    end else if (m_busy) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy = 1'b0; m_ready = 1'b1; m_error = p_err;
        m_div = p_div; m_mod = p_mod;
      end
    end else if (go) begin
      m_busy = 1'b1; m_ready = 1'b0; m_error = 1'b0;
      m_left = (b == 0) ? 2 : W + 1;
      ref_div(a, b, sgn, p_div, p_mod, p_err);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if ({busy, ready, error, div, mod} !== {m_busy, m_ready, m_error, m_div, m_mod}) begin
        fails++;
        if (nprint < 20) begin
          nprint++;
          $display("FAIL cycle t=%0t actual busy=%b ready=%b err=%b div=%h mod=%h required busy=%b ready=%b err=%b div=%h mod=%h",
                   $time, busy, ready, error, div, mod, m_busy, m_ready, m_error, m_div, m_mod);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic pin_model(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rs,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input logic ee,
                           input string nm);
    logic [W-1:0] q, r;
    logic e;
    ref_div(ra, rb, rs, q, r, e);
    chk({"model ", nm}, {q, r, 31'd0, e}, {eq, er, 31'd0, ee});
  endtask

  task automatic wait_ready(input string nm, output bit ok);
    int n = 0;
    while (ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 40);
    if (!ok) chk({nm, " ready timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run_op(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rs,
                        input logic [W-1:0] ed, input logic [W-1:0] em, input logic ee,
                        input string nm);
    bit ok;
    @(negedge clk);
    a = ra; b = rb; sgn = rs; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_ready(nm, ok);
    if (ok) begin
      chk({nm, " div"}, 64'(div), 64'(ed));
      chk({nm, " mod"}, 64'(mod), 64'(em));
      chk({nm, " error"}, 64'(error), 64'(ee));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, rise_cnt;
    logic prev_ready;
    bit ok;
    logic [W-1:0] pa [3];
    logic [W-1:0] pb [3];
    logic [W-1:0] pd [3];
    logic [W-1:0] pm [3];

    // Literal pins on the reference model.
    pin_model(16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, "-7/2");
    pin_model(16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0, "7/-2");
    pin_model(16'hFFF9, 16'hFFFE, 1'b1, 16'h0003, 16'hFFFF, 1'b0, "-7/-2");
    pin_model(16'h0007, 16'h0002, 1'b1, 16'h0003, 16'h0001, 1'b0, "7/2");
    pin_model(16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b1, "ovf");
    pin_model(16'd100,  16'd7,    1'b0, 16'd14,   16'd2,    1'b0, "100/7");
    pin_model(16'h1234, 16'h0000, 1'b1, 16'hFFFF, 16'h1234, 1'b1, "div0");

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset state", {busy, ready, error, div, mod}, 64'd0);
    chk_en = 1'b1;

    run_op(16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, "s -7/2");
    run_op(16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0, "s 7/-2");
    run_op(16'hFFF9, 16'hFFFE, 1'b1, 16'h0003, 16'hFFFF, 1'b0, "s -7/-2");
    run_op(16'h0007, 16'h0002, 1'b1, 16'h0003, 16'h0001, 1'b0, "s 7/2");
    run_op(16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b1, "s ovf");
    run_op(16'h1234, 16'h0000, 1'b1, 16'hFFFF, 16'h1234, 1'b1, "div0");
    run_op(16'd60000, 16'd7,   1'b0, 16'd8571, 16'd3,    1'b0, "u 60000/7");

    // Busy rejection: a second go three edges later is ignored.
    @(negedge clk);
    a = 16'd100; b = 16'd7; sgn = 1'b0; go = 1'b1;
    busy_cnt = 0; rise_cnt = 0; prev_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 0) go = 1'b0;
      if (i == 2) begin a = 16'd5; b = 16'd5; go = 1'b1; end
      if (i == 3) go = 1'b0;
      busy_cnt += int'(busy);
      if (ready && !prev_ready) rise_cnt++;
      prev_ready = ready;
    end
    chk("busy-rej busy cycles", 64'(busy_cnt), 64'd17);
    chk("busy-rej ready pulses", 64'(rise_cnt), 64'd1);
    chk("busy-rej result", {32'd0, div, mod}, {32'd0, 16'd14, 16'd2});

    // Reset five cycles into an operation aborts it.
    @(negedge clk);
    a = 16'd30000; b = 16'd7; sgn = 1'b0; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid-op reset outputs", {busy, ready, error, div, mod}, 64'd0);
    repeat (20) @(negedge clk);
    chk("after reset no result", 64'(ready), 64'd0);
    run_op(16'd1000, 16'd10, 1'b0, 16'd100, 16'd0, 1'b0, "post-reset 1000/10");

    // Back-to-back with go held high.
    pa[0] = 16'd50000; pb[0] = 16'd3;     pd[0] = 16'd16666; pm[0] = 16'd2;
    pa[1] = 16'd12345; pb[1] = 16'd100;   pd[1] = 16'd123;   pm[1] = 16'd45;
    pa[2] = 16'hFFFF;  pb[2] = 16'hFFFF;  pd[2] = 16'd1;     pm[2] = 16'd0;
    @(negedge clk);
    a = pa[0]; b = pb[0]; sgn = 1'b0; go = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k > 0) chk($sformatf("b2b ready single cycle %0d", k), 64'(ready), 64'd0);
      if (k < 2) begin a = pa[k+1]; b = pb[k+1]; end
      else go = 1'b0;
      wait_ready($sformatf("b2b %0d", k), ok);
      if (ok) chk($sformatf("b2b result %0d", k), {32'd0, div, mod}, {32'd0, pd[k], pm[k]});
    end
    @(negedge clk);

    // Randomized traffic, including go while busy and occasional resets.
    for (int i = 0; i < 6000; i++) begin
      int sel;
      @(negedge clk);
      rst = ($urandom_range(0, 499) == 0);
      go  = ($urandom_range(0, 3) != 0);
      sgn = $urandom_range(0, 1);
      a   = W'($urandom);
      sel = $urandom_range(0, 15);
      case (sel)
        0:       b = '0;
        1:       begin b = 16'hFFFF; a = 16'h8000; sgn = 1'b1; end
        2, 3:    b = W'($urandom_range(1, 15));
        4:       b = 16'hFFFF;
        default: b = W'($urandom);
      endcase
    end
    @(negedge clk);
    rst = 1'b0; go = 1'b0;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
